// File: rtl/memory_bank_pkg.sv
// memory_bank_pkg: shared address offsets, scan-chain length and parameter checks for memory_bank_io.
package memory_bank_pkg;

  // IO and status registers sit directly above the last memory word.
  localparam int unsigned IO_OFFSET   = 0;
  localparam int unsigned STAT_OFFSET = 1;

  function automatic int unsigned chain_len(
    input int unsigned mem_size,
    input int unsigned data_width,
    input int unsigned num_in,
    input int unsigned num_out,
    input int unsigned key_width,
    input bit          key_en
  );
    return mem_size * data_width + 2 * num_in + num_out + (key_en ? key_width : 0);
  endfunction

  function automatic bit params_ok(
    input int unsigned addr_width,
    input int unsigned data_width,
    input int unsigned mem_size,
    input int unsigned num_in,
    input int unsigned num_out
  );
    return (mem_size + 2 <= (1 << addr_width)) &&
           (num_in >= 1) && (num_in < data_width) &&
           (num_out == data_width - num_in);
  endfunction

endpackage

// File: rtl/memory_bank_io_scan_word_reg.sv
// scan_word_reg: register with synchronous clear, scan shift (highest priority after reset) and load enable.
module scan_word_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_enable,
  input  logic             scan_in,
  input  logic             write_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             scan_out
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] shifted;

  if (WIDTH > 1) begin : g_wide
    assign shifted = {q_q[WIDTH-2:0], scan_in};
  end else begin : g_bit
    assign shifted = scan_in;
  end

  always_comb begin
    q_d = q_q;
    if (scan_enable) begin
      q_d = shifted;
    end else if (write_en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q        = q_q;
  assign scan_out = q_q[WIDTH-1];

endmodule

// File: rtl/memory_bank_io.sv
// memory_bank_io: scannable memory bank with a memory-mapped output register and synchronised, edge-flagged inputs.
// Defining MEMBANK_KEY_EN appends a scan-only locking key register as the last chain segment.
module memory_bank_io
  import memory_bank_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 5,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           MEM_SIZE   = 15,
  parameter int unsigned           NUM_IN     = 1,
  parameter int unsigned           NUM_OUT    = 7,
  parameter int unsigned           KEY_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] OOR_VALUE  = DATA_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  scan_enable,
  input  logic                  scan_in,
  output logic                  scan_out,
  input  logic [NUM_IN-1:0]     in_pins,
  output logic [NUM_OUT-1:0]    out_pins,
  output logic [KEY_WIDTH-1:0]  locking_key
);

  localparam logic [ADDR_WIDTH-1:0] IO_ADDR   = ADDR_WIDTH'(MEM_SIZE + IO_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(MEM_SIZE + STAT_OFFSET);

  if (!params_ok(ADDR_WIDTH, DATA_WIDTH, MEM_SIZE, NUM_IN, NUM_OUT)) begin : g_param_err
    $error("memory_bank_io: illegal ADDR_WIDTH/DATA_WIDTH/MEM_SIZE/NUM_IN/NUM_OUT combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [MEM_SIZE:0]     mem_chain;
  logic [NUM_IN-1:0]     sync1_d, sync1_q;
  logic [NUM_IN-1:0]     prev_d, prev_q;
  logic [NUM_IN-1:0]     in_sync_q;
  logic [NUM_IN-1:0]     flags_d, flags_q;
  logic [NUM_IN-1:0]     w1c_mask;
  logic [NUM_OUT-1:0]    out_reg_q;
  logic                  in_sync_so, out_reg_so, flags_so;

  assign mem_chain[0] = scan_in;

  for (genvar i = 0; i < MEM_SIZE; i++) begin : g_mem
    scan_word_reg #(.WIDTH(DATA_WIDTH)) u_word (
      .clk         (clk),
      .rst         (rst),
      .scan_enable (scan_enable),
      .scan_in     (mem_chain[i]),
      .write_en    (write_enable && (address == ADDR_WIDTH'(i))),
      .d           (data_in),
      .q           (mem_q[i]),
      .scan_out    (mem_chain[i+1])
    );
  end

  // Set wins over a same-cycle clear; scan priority is applied inside the register.
  always_comb begin
    sync1_d  = in_pins;
    prev_d   = scan_enable ? prev_q : in_sync_q;
    w1c_mask = '0;
    if (write_enable && !scan_enable && (address == STAT_ADDR)) begin
      w1c_mask = data_in[NUM_IN-1:0];
    end
    flags_d = (flags_q & ~w1c_mask) | (in_sync_q & ~prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
    end
  end

  scan_word_reg #(.WIDTH(NUM_IN)) u_in_sync (
    .clk         (clk),
    .rst         (rst),
    .scan_enable (scan_enable),
    .scan_in     (mem_chain[MEM_SIZE]),
    .write_en    (1'b1),
    .d           (sync1_q),
    .q           (in_sync_q),
    .scan_out    (in_sync_so)
  );

  scan_word_reg #(.WIDTH(NUM_OUT)) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .scan_enable (scan_enable),
    .scan_in     (in_sync_so),
    .write_en    (write_enable && (address == IO_ADDR)),
    .d           (data_in[DATA_WIDTH-1:NUM_IN]),
    .q           (out_reg_q),
    .scan_out    (out_reg_so)
  );

  scan_word_reg #(.WIDTH(NUM_IN)) u_flags (
    .clk         (clk),
    .rst         (rst),
    .scan_enable (scan_enable),
    .scan_in     (out_reg_so),
    .write_en    (1'b1),
    .d           (flags_d),
    .q           (flags_q),
    .scan_out    (flags_so)
  );

`ifdef MEMBANK_KEY_EN
  logic [KEY_WIDTH-1:0] key_q;
  logic                 key_so;

  scan_word_reg #(.WIDTH(KEY_WIDTH)) u_key (
    .clk         (clk),
    .rst         (rst),
    .scan_enable (scan_enable),
    .scan_in     (flags_so),
    .write_en    (1'b0),
    .d           ('0),
    .q           (key_q),
    .scan_out    (key_so)
  );

  assign locking_key = key_q;
  assign scan_out    = key_so;
`else
  assign locking_key = '0;
  assign scan_out    = flags_so;
`endif

  always_comb begin
    data_out = OOR_VALUE;
    for (int unsigned i = 0; i < MEM_SIZE; i++) begin
      if (address == ADDR_WIDTH'(i)) begin
        data_out = mem_q[i];
      end
    end
    if (address == IO_ADDR) begin
      data_out = {out_reg_q, in_sync_q};
    end
    if (address == STAT_ADDR) begin
      data_out = {{(DATA_WIDTH-NUM_IN){1'b0}}, flags_q};
    end
  end

  assign out_pins = out_reg_q;

endmodule

// File: tb/tb_memory_bank_io.sv
// tb_memory_bank_io: randomized + directed scoreboard bench for memory_bank_io against a whole-state reference model.
`timescale 1ns/1ps
module tb_memory_bank_io;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned MS = 15;
  localparam int unsigned NI = 1;
  localparam int unsigned NO = 7;
  localparam int unsigned KW = 16;
`ifdef MEMBANK_KEY_EN
  localparam int unsigned L = MS*DW + 2*NI + NO + KW;
`else
  localparam int unsigned L = MS*DW + 2*NI + NO;
`endif

  logic          clk = 1'b1;
  logic          rst = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] data_out;
  logic          scan_enable = 1'b0;
  logic          scan_in = 1'b0;
  logic          scan_out;
  logic [NI-1:0] in_pins = '0;
  logic [NO-1:0] out_pins;
  logic [KW-1:0] locking_key;

  memory_bank_io #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_SIZE   (MS),
    .NUM_IN     (NI),
    .NUM_OUT    (NO),
    .KEY_WIDTH  (KW),
    .OOR_VALUE  (8'h01)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out),
    .scan_enable  (scan_enable),
    .scan_in      (scan_in),
    .scan_out     (scan_out),
    .in_pins      (in_pins),
    .out_pins     (out_pins),
    .locking_key  (locking_key)
  );

  always #5 clk = ~clk;

  // Reference state; the scan chain is viewed as one L-bit vector whose MSB is scan_out.
  logic [DW-1:0] m_mem [MS];
  logic [NO-1:0] m_out;
  logic          m_sync1, m_insync, m_prev, m_flag;
  logic [KW-1:0] m_key;

  typedef struct {
    int unsigned kind;
    logic [31:0] exp;
  } chk_t;
  chk_t sbq[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [L-1:0] pack_state();
    logic [L-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MS; i++) v[i*DW +: DW] = m_mem[i];
    v[MS*DW] = m_insync;
    v[MS*DW+1 +: NO] = m_out;
    v[MS*DW+1+NO] = m_flag;
`ifdef MEMBANK_KEY_EN
    v[L-1 -: KW] = m_key;
`endif
    return v;
  endfunction

  task automatic unpack_state(input logic [L-1:0] v);
    for (int unsigned i = 0; i < MS; i++) m_mem[i] = v[i*DW +: DW];
    m_insync = v[MS*DW];
    m_out    = v[MS*DW+1 +: NO];
    m_flag   = v[MS*DW+1+NO];
`ifdef MEMBANK_KEY_EN
    m_key    = v[L-1 -: KW];
`endif
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    int unsigned ai;
    ai = int'(a);
    if (ai < MS) return m_mem[ai];
    if (ai == MS) return {m_out, m_insync};
    if (ai == MS + 1) return {7'b0, m_flag};
    return 8'h01;
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < MS; i++) m_mem[i] = '0;
    m_out = '0; m_sync1 = 1'b0; m_insync = 1'b0; m_prev = 1'b0; m_flag = 1'b0; m_key = '0;
  endtask

  task automatic model_edge();
    logic [L-1:0] v;
    logic         nf;
    int unsigned  ai;
    if (rst) begin
      model_reset();
      return;
    end
    ai = int'(address);
    if (scan_enable) begin
      v = pack_state();
      v = {v[L-2:0], scan_in};
      unpack_state(v);
    end else begin
      nf = m_insync & ~m_prev;
      if (!(write_enable && ai == MS + 1 && data_in[0])) nf = nf | m_flag;
      else nf = nf | 1'b0;
      m_prev   = m_insync;
      m_insync = m_sync1;
      m_flag   = nf;
      if (write_enable && ai < MS) m_mem[ai] = data_in;
      if (write_enable && ai == MS) m_out = data_in[DW-1:1];
    end
    m_sync1 = in_pins[0];
  endtask

  task automatic push(input int unsigned kind, input logic [31:0] exp);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    sbq.push_back(c);
  endtask

  task automatic push_model();
    logic [L-1:0] v;
    v = pack_state();
    push(0, 32'(m_read(address)));
    push(1, 32'(m_out));
    push(2, 32'(m_key));
    push(3, 32'(v[L-1]));
  endtask

  // Inputs are set just after a rising edge; expectations are queued, then the edge is taken.
  task automatic cycle();
    push_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    scan_enable  = 1'b0;
    scan_in      = 1'b0;
  endtask

  initial begin : monitor
    chk_t        c;
    logic [31:0] act;
    string       nm;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        case (c.kind)
          0: begin act = 32'(data_out);    nm = "data_out";    end
          1: begin act = 32'(out_pins);    nm = "out_pins";    end
          2: begin act = 32'(locking_key); nm = "locking_key"; end
          default: begin act = 32'(scan_out); nm = "scan_out"; end
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s @%0t addr=%0d: got %0h expected %0h", nm, $time, address, act, c.exp);
        end
      end
    end
  end

  logic [L-1:0]  p1, p2;
  logic [DW-1:0] w0;
  logic [KW-1:0] kv;

  initial begin : stim
    model_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      model_edge();
      #1;
    end

    // Reset state across the whole address map, still holding reset.
    for (int unsigned a = 0; a <= MS + 2; a++) begin
      address = AW'(a);
      push(0, (a == MS + 2) ? 32'h01 : 32'h00);
      cycle();
    end
    rst = 1'b0;
    address = '0;
    push(1, 32'h0);
    push(2, 32'h0);
    push(3, 32'h0);
    cycle();

    // Basic memory and IO writes.
    write_enable = 1'b1; address = 5'd3;  data_in = 8'hA5; cycle();
    write_enable = 1'b1; address = 5'd15; data_in = 8'hFE; cycle();
    write_enable = 1'b0; address = 5'd3;  push(0, 32'hA5); push(1, 32'h7F); cycle();
    address = 5'd15; push(0, 32'hFE); cycle();

    // Input edge timing and write-1-to-clear.
    in_pins = 1'b1; address = 5'd15; cycle();
    push(0, 32'hFE); cycle();
    push(0, 32'hFF); cycle();
    address = 5'd16; push(0, 32'h01); cycle();
    write_enable = 1'b1; data_in = 8'h01; cycle();
    write_enable = 1'b0; push(0, 32'h00); cycle();

    // Clear issued in the same cycle the edge is detected: the set must win.
    in_pins = 1'b0;
    repeat (4) cycle();
    in_pins = 1'b1; cycle();
    cycle();
    write_enable = 1'b1; address = 5'd16; data_in = 8'h01; cycle();
    write_enable = 1'b0; push(0, 32'h01); cycle();
    write_enable = 1'b1; cycle();
    idle();

    // Full-chain scan: pattern p1 must reappear on scan_out while p2 is shifted in.
    for (int unsigned k = 0; k < L; k++) begin
      p1[k] = 1'($urandom);
      p2[k] = 1'($urandom);
    end
    scan_enable = 1'b1;
    for (int unsigned k = 0; k < L; k++) begin
      scan_in = p1[k];
      cycle();
    end
    for (int unsigned k = 0; k < L; k++) begin
      scan_in = p2[k];
      push(3, 32'(p1[k]));
      cycle();
    end
    idle();
    for (int unsigned j = 0; j < DW; j++) w0[j] = p2[L-1-j];
    address = 5'd0;
    push(0, 32'(w0));
    cycle();

    // Locking key loaded by scan only.
    kv = 16'hBEEF;
`ifdef MEMBANK_KEY_EN
    scan_enable = 1'b1;
    for (int unsigned k = 0; k < L; k++) begin
      scan_in = (k < KW) ? kv[KW-1-k] : 1'b0;
      cycle();
    end
    idle();
    push(2, 32'hBEEF); cycle();
    write_enable = 1'b1; address = 5'd5;  data_in = 8'h3C; cycle();
    write_enable = 1'b1; address = 5'd15; data_in = 8'h81; cycle();
    write_enable = 1'b1; address = 5'd16; data_in = 8'hFF; cycle();
    idle();
    push(2, 32'hBEEF); cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; push(2, 32'h0); push(3, 32'h0); cycle();
`else
    write_enable = 1'b1; address = 5'd5; data_in = kv[7:0]; cycle();
    idle();
    push(2, 32'h0); cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; push(2, 32'h0); cycle();
`endif

    // Randomized traffic, including scan bursts and occasional resets.
    for (int unsigned n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      scan_enable  = ($urandom_range(0, 5) == 0);
      scan_in      = 1'($urandom);
      write_enable = 1'($urandom);
      address      = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, MS + 2));
      data_in      = DW'($urandom);
      if ($urandom_range(0, 3) == 0) in_pins = ~in_pins;
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();
    @(negedge clk);
    #1;

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
